vga_scanout: RTL and testbench
==============================

Name: vga_scanout

Overview:
- Downstream stage of the TRS-80 capture path: reads the 800x240 1-bit frame buffer in the dual-port RAM's read port and generates 800x600@60 Hz VGA.
- Each source line is output twice (line doubling) to form a 480-line image, centred vertically. The 60 lines above and below it are black.
- Colour is a monochrome phosphor tint selected by a 2-bit input.

Parameters:
- H_VIS, 800, visible pixels per line
- H_FP, 40, horizontal front porch (pixels)
- H_SYNC, 128, hsync width (pixels)
- H_BP, 88, horizontal back porch (pixels)
- V_VIS, 600, visible lines
- V_FP, 1, vertical front porch (lines)
- V_SYNC, 4, vsync width (lines)
- V_BP, 23, vertical back porch (lines)
- V_OFFSET, 60, first visible line carrying source line 0
- SRC_LINES, 240, source lines in the frame buffer
- SYNC_POL, 1, active level of hsync/vsync
- RD_LAT, 2, RAM read latency in cycles from raddr to rdata (1..3)

Ports:
- pixclk  in  1  40 MHz VGA pixel clock
- reset_n  in  1  asynchronous active-low reset
- rdata  in  1  pixel bit from dual-port RAM (1 = lit)
- tint  in  2  colour select: 00 green, 01 amber, 10 white, 11 blue; asynchronous DIP input
- raddr  out  18  RAM read address
- vga_r  out  4  red
- vga_g  out  4  green
- vga_b  out  4  blue
- vga_hs  out  1  horizontal sync
- vga_vs  out  1  vertical sync
- frame_start  out  1  one-cycle pulse, aligned to the first pin-level pixel of line 0

Behaviour:
- Interface: one clock, pixclk. reset_n is asynchronous, active-low.
- Reset values:
  - hcnt=0, vcnt=0, line_base=0, raddr=0.
  - vga_r/g/b=0, vga_hs=vga_vs=!SYNC_POL, frame_start=0.
  - All pipeline stages cleared to blank / sync-inactive.
  - tint_reg=00.
  - Reset mid-frame restarts at hcnt=0, vcnt=0 on the first clock after release.
- Counters:
  - hcnt runs 0..H_TOTAL-1, where H_TOTAL=H_VIS+H_FP+H_SYNC+H_BP=1056.
  - vcnt increments when hcnt wraps and runs 0..V_TOTAL-1 (V_TOTAL=628). Both wrap to 0.
- Syncs:
  - hs_raw is active for H_VIS+H_FP <= hcnt < H_VIS+H_FP+H_SYNC (840..967).
  - vs_raw is active for 601 <= vcnt < 605.
- Window:
  - win = (hcnt < H_VIS) and (V_OFFSET <= vcnt < V_OFFSET+2*SRC_LINES), i.e. vcnt 60..539.
  - src_y = (vcnt - V_OFFSET) >> 1.
- Address generation (no multiplier):
  - line_base loads 0 when vcnt wraps to 0.
  - line_base += H_VIS at the hcnt wrap that ends an odd window line (vcnt-V_OFFSET odd).
  - raddr is registered: raddr <= win ? line_base + hcnt : 0. Stage 1 follows counter state.
  - Maximum address is 191999; the 18-bit width suffices. raddr never exceeds 191999.
- Pipeline:
  - rdata for stage-1 raddr arrives RD_LAT cycles later.
  - Output registers capture it at stage RD_LAT+2.
  - win, hs_raw and vs_raw pass through a shift chain of length RD_LAT+2, so syncs stay aligned with pixels.
  - Latency from counter state to pins is RD_LAT+2 cycles (4 at default).
- Pixel colour:
  - The pixel is lit when the delayed win=1 and rdata=1. Otherwise RGB=0 (blanking forced black).
  - Lit colours: green (0,F,0); amber (F,A,0); white (F,F,F); blue (4,8,F).
- Tint:
  - tint is double-flopped.
  - tint_reg updates only on the cycle where hcnt=0 and vcnt=0, so there is no mid-frame colour change.
- frame_start: 1 for exactly one cycle, when the delayed pixel is (hcnt=0, vcnt=V_OFFSET).
- rdata is ignored whenever the delayed win=0.

Test Plan:
- Reset then free-run 2 frames:
  - hs period 1056 cycles, low(active) width 128.
  - vs period 663168 cycles, width 4224.
  - First hs edge 844 cycles after reset release (840+RD_LAT+2).
- RAM model returns rdata=1 only at address 800 (src line 1, x 0):
  - Lit (0,F,0) at pin lines 62 and 63, column 0.
  - All other pixels 0.
- Check raddr sequence at hcnt=0:
  - vcnt 60→0, 61→0, 62→800, 539→191200.
  - At (hcnt=799, vcnt=539) raddr=191999.
  - Outside window raddr=0.
- rdata tied 1:
  - Pins black for vcnt<60, vcnt≥540 and hcnt≥800 (delayed).
  - Lit pixel count per frame 384000.
- Toggle tint 00→01 mid-frame:
  - Colour stays green until the next frame's first visible pixel, then (F,A,0).
  - frame_start pulses exactly once per frame.
- Assert reset_n low at vcnt=300:
  - Outputs immediately go blank with syncs inactive (no clock needed).
  - After release, timing restarts from hcnt=0, vcnt=0.

Source files
------------

// File: rtl/vga_scanout.sv
// VGA scan-out of a 1-bit, line-doubled frame buffer held in a dual-port RAM.
// Counters drive the RAM address. Window, syncs and the frame marker ride a delay chain matched to the RAM read latency.
module vga_scanout #(
    parameter int H_VIS     = 800,
    parameter int H_FP      = 40,
    parameter int H_SYNC    = 128,
    parameter int H_BP      = 88,
    parameter int V_VIS     = 600,
    parameter int V_FP      = 1,
    parameter int V_SYNC    = 4,
    parameter int V_BP      = 23,
    parameter int V_OFFSET  = 60,
    parameter int SRC_LINES = 240,
    parameter bit SYNC_POL  = 1'b1,
    parameter int RD_LAT    = 2
) (
    input  logic        pixclk,
    input  logic        reset_n,
    input  logic        rdata,
    input  logic [1:0]  tint,
    output logic [17:0] raddr,
    output logic [3:0]  vga_r,
    output logic [3:0]  vga_g,
    output logic [3:0]  vga_b,
    output logic        vga_hs,
    output logic        vga_vs,
    output logic        frame_start
);

    localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam bit OFF_ODD = (V_OFFSET % 2) == 1;

    logic [HW-1:0] hcnt;
    logic [VW-1:0] vcnt;
    logic          h_last;
    logic          v_last;
    logic          in_vwin;
    logic          win;
    logic          hs_raw;
    logic          vs_raw;
    logic          fs_raw;
    logic          line_odd;
    logic [17:0]   line_base;
    logic [RD_LAT:0] win_d;
    logic [RD_LAT:0] hs_d;
    logic [RD_LAT:0] vs_d;
    logic [RD_LAT:0] fs_d;
    logic [1:0]    tint_s1;
    logic [1:0]    tint_s2;
    logic [1:0]    tint_reg;
    logic [3:0]    col_r;
    logic [3:0]    col_g;
    logic [3:0]    col_b;
    logic          lit;

    assign h_last   = (hcnt == HW'(H_TOTAL - 1));
    assign v_last   = (vcnt == VW'(V_TOTAL - 1));
    assign in_vwin  = (vcnt >= VW'(V_OFFSET)) && (vcnt < VW'(V_OFFSET + 2 * SRC_LINES));
    assign win      = in_vwin && (hcnt < HW'(H_VIS));
    assign hs_raw   = (hcnt >= HW'(H_VIS + H_FP)) && (hcnt < HW'(H_VIS + H_FP + H_SYNC));
    assign vs_raw   = (vcnt >= VW'(V_VIS + V_FP)) && (vcnt < VW'(V_VIS + V_FP + V_SYNC));
    assign fs_raw   = (hcnt == '0) && (vcnt == VW'(V_OFFSET));
    assign line_odd = vcnt[0] ^ OFF_ODD;

    always_ff @(posedge pixclk or negedge reset_n) begin
        if (!reset_n) begin
            hcnt <= '0;
            vcnt <= '0;
        end else if (h_last) begin
            hcnt <= '0;
            vcnt <= v_last ? '0 : vcnt + VW'(1);
        end else begin
            hcnt <= hcnt + HW'(1);
        end
    end

    // Each source line is shown twice, so the base only advances after the second copy.
    always_ff @(posedge pixclk or negedge reset_n) begin
        if (!reset_n) begin
            line_base <= '0;
        end else if (h_last) begin
            if (v_last) begin
                line_base <= '0;
            end else if (in_vwin && line_odd) begin
                line_base <= line_base + 18'(H_VIS);
            end
        end
    end

    always_ff @(posedge pixclk or negedge reset_n) begin
        if (!reset_n) begin
            raddr <= '0;
            win_d <= '0;
            hs_d  <= '0;
            vs_d  <= '0;
            fs_d  <= '0;
        end else begin
            raddr <= win ? line_base + 18'(hcnt) : '0;
            win_d <= {win_d[RD_LAT-1:0], win};
            hs_d  <= {hs_d[RD_LAT-1:0], hs_raw};
            vs_d  <= {vs_d[RD_LAT-1:0], vs_raw};
            fs_d  <= {fs_d[RD_LAT-1:0], fs_raw};
        end
    end

    // The tint DIP is asynchronous; it is only adopted at the top of a frame.
    always_ff @(posedge pixclk or negedge reset_n) begin
        if (!reset_n) begin
            tint_s1  <= 2'b00;
            tint_s2  <= 2'b00;
            tint_reg <= 2'b00;
        end else begin
            tint_s1 <= tint;
            tint_s2 <= tint_s1;
            if ((hcnt == '0) && (vcnt == '0)) begin
                tint_reg <= tint_s2;
            end
        end
    end

    always_comb begin
        col_r = 4'h0;
        col_g = 4'h0;
        col_b = 4'h0;
        case (tint_reg)
            2'b00: begin col_r = 4'h0; col_g = 4'hF; col_b = 4'h0; end
            2'b01: begin col_r = 4'hF; col_g = 4'hA; col_b = 4'h0; end
            2'b10: begin col_r = 4'hF; col_g = 4'hF; col_b = 4'hF; end
            default: begin col_r = 4'h4; col_g = 4'h8; col_b = 4'hF; end
        endcase
    end

    assign lit = win_d[RD_LAT] & rdata;

    always_ff @(posedge pixclk or negedge reset_n) begin
        if (!reset_n) begin
            vga_r       <= 4'h0;
            vga_g       <= 4'h0;
            vga_b       <= 4'h0;
            vga_hs      <= ~SYNC_POL;
            vga_vs      <= ~SYNC_POL;
            frame_start <= 1'b0;
        end else begin
            vga_r       <= lit ? col_r : 4'h0;
            vga_g       <= lit ? col_g : 4'h0;
            vga_b       <= lit ? col_b : 4'h0;
            vga_hs      <= hs_d[RD_LAT] ? SYNC_POL : ~SYNC_POL;
            vga_vs      <= vs_d[RD_LAT] ? SYNC_POL : ~SYNC_POL;
            frame_start <= fs_d[RD_LAT];
        end
    end

endmodule

// File: tb/tb_vga_scanout.sv
// Bench for vga_scanout: a shrunken-timing instance scoreboarded pixel by pixel, plus a full-timing instance for hsync timing.
`timescale 1ns/1ps
module tb_vga_scanout;

    localparam int          FRAME = 224;
    localparam logic [11:0] GREEN = 12'h0F0;
    localparam logic [11:0] AMBER = 12'hFA0;
    localparam logic [11:0] BLACK = 12'h000;

    typedef struct {
        bit          is_addr;
        string       name;
        int          cyc;
        logic [11:0] rgb;
        logic        hs;
        logic        vs;
        logic        fs;
        logic [17:0] addr;
    } exp_t;

    logic        pixclk = 1'b0;
    logic        reset_n;
    logic        rdata;
    logic        rd_pipe;
    logic [1:0]  tint;
    logic [17:0] raddr;
    logic [3:0]  vga_r, vga_g, vga_b;
    logic        vga_hs, vga_vs, frame_start;
    logic        ram_mode;

    logic        reset_n_full;
    logic        rdata_full = 1'b0;
    logic [1:0]  tint_full = 2'b00;
    logic [17:0] raddr_full;
    logic [3:0]  r_full, g_full, b_full;
    logic        hs_full, vs_full, fs_full;

    exp_t exp_q[$];
    exp_t mon_e;
    int   vectors = 0;
    int   miscompares = 0;
    int   cyc;
    int   cyc_full;
    int   seg = 0;

    int   hs_first = -1, hs_rise = -1, hs_period = -1, hs_width = -1;
    int   vs_rise = -1, vs_period = -1, vs_width = -1;
    int   lit_cnt[3];
    int   fs_cnt[3];
    logic prev_hs = 1'b0, prev_vs = 1'b0;

    int   full_rise1 = -1, full_fall1 = -1, full_rise2 = -1, full_bad = 0;
    logic prev_hs_full = 1'b0;

    always #5 pixclk = ~pixclk;

    vga_scanout #(
        .H_VIS(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_VIS(10), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .V_OFFSET(2), .SRC_LINES(3), .SYNC_POL(1'b1), .RD_LAT(2)
    ) dut (
        .pixclk(pixclk), .reset_n(reset_n), .rdata(rdata), .tint(tint),
        .raddr(raddr), .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
        .vga_hs(vga_hs), .vga_vs(vga_vs), .frame_start(frame_start)
    );

    vga_scanout dut_full (
        .pixclk(pixclk), .reset_n(reset_n_full), .rdata(rdata_full), .tint(tint_full),
        .raddr(raddr_full), .vga_r(r_full), .vga_g(g_full), .vga_b(b_full),
        .vga_hs(hs_full), .vga_vs(vs_full), .frame_start(fs_full)
    );

    // Two-cycle read-latency RAM: either only address 8 is lit, or every address is.
    always @(posedge pixclk) begin
        rd_pipe <= ram_mode ? 1'b1 : (raddr == 18'd8);
        rdata   <= rd_pipe;
    end

    always @(posedge pixclk or negedge reset_n) begin
        if (!reset_n) cyc <= 0;
        else          cyc <= cyc + 1;
    end

    always @(posedge pixclk or negedge reset_n_full) begin
        if (!reset_n_full) cyc_full <= 0;
        else               cyc_full <= cyc_full + 1;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic pushPin(input string name, input int c, input logic [11:0] rgb,
                           input logic hs, input logic vs, input logic fs);
        exp_t e;
        e.is_addr = 1'b0; e.name = name; e.cyc = c;
        e.rgb = rgb; e.hs = hs; e.vs = vs; e.fs = fs; e.addr = '0;
        exp_q.push_back(e);
    endtask

    task automatic pushAddr(input string name, input int c, input logic [17:0] addr);
        exp_t e;
        e.is_addr = 1'b1; e.name = name; e.cyc = c;
        e.rgb = '0; e.hs = 1'b0; e.vs = 1'b0; e.fs = 1'b0; e.addr = addr;
        exp_q.push_back(e);
    endtask

    // Pixel (h,v) of frame f reaches the pins at cycle 224*f + 16*v + h + 4; raddr for it at one cycle after its state.
    task automatic applyStimulus(input int phase);
        if (phase == 0) begin
            pushPin ("pipe_clear",      3, BLACK, 0, 0, 0);
            pushPin ("hs_before",      13, BLACK, 0, 0, 0);
            pushPin ("hs_start",       14, BLACK, 1, 0, 0);
            pushPin ("hs_end",         16, BLACK, 1, 0, 0);
            pushPin ("hs_after",       17, BLACK, 0, 0, 0);
            pushAddr("addr_v2_h0",     33, 18'd0);
            pushPin ("fs_before",      35, BLACK, 0, 0, 0);
            pushPin ("fs_pulse_f0",    36, BLACK, 0, 0, 1);
            pushPin ("fs_after",       37, BLACK, 0, 0, 0);
            pushAddr("addr_v3_h0",     49, 18'd0);
            pushPin ("dark_v3_h0",     52, BLACK, 0, 0, 0);
            pushAddr("addr_v4_h0",     65, 18'd8);
            pushPin ("lit_v4_h0",      68, GREEN, 0, 0, 0);
            pushPin ("dark_v4_h1",     69, BLACK, 0, 0, 0);
            pushAddr("addr_v5_h3",     84, 18'd11);
            pushPin ("lit_v5_h0",      84, GREEN, 0, 0, 0);
            pushPin ("dark_v6_h0",    100, BLACK, 0, 0, 0);
            pushAddr("addr_v7_h0",    113, 18'd16);
            pushAddr("addr_max",      120, 18'd23);
            pushAddr("addr_hblank",   121, 18'd0);
            pushAddr("addr_vblank",   129, 18'd0);
            pushPin ("vs_before",     179, BLACK, 0, 0, 0);
            pushPin ("vs_start",      180, BLACK, 0, 1, 0);
            pushPin ("vs_end",        211, BLACK, 0, 1, 0);
            pushPin ("vs_after",      212, BLACK, 0, 0, 0);
            pushPin ("mask_top",      244, BLACK, 0, 0, 0);
            pushAddr("addr_f1_v2",    257, 18'd0);
            pushPin ("fs_pulse_f1",   260, GREEN, 0, 0, 1);
            pushPin ("mask_right",    268, BLACK, 0, 0, 0);
            pushAddr("addr_f1_v4",    289, 18'd8);
            pushPin ("green_held",    324, GREEN, 0, 0, 0);
            pushPin ("lit_last",      347, GREEN, 0, 0, 0);
            pushPin ("mask_right2",   348, BLACK, 0, 0, 0);
            pushPin ("mask_bottom",   356, BLACK, 0, 0, 0);
            pushPin ("amber_first",   484, AMBER, 0, 0, 1);
            pushPin ("amber_v5",      532, AMBER, 0, 0, 0);
            pushPin ("pre_reset_lit", 759, AMBER, 0, 0, 0);
        end else begin
            pushPin ("rst_hs_before",  13, BLACK, 0, 0, 0);
            pushPin ("rst_hs_start",   14, BLACK, 1, 0, 0);
            pushPin ("rst_fs_green",   36, GREEN, 0, 0, 1);
            pushAddr("rst_addr_v4",    65, 18'd8);
            pushPin ("rst_lit_v4",     68, GREEN, 0, 0, 0);
            pushPin ("rst_fs_amber",  260, AMBER, 0, 0, 1);
            pushPin ("rst_amber_v4",  292, AMBER, 0, 0, 0);
        end
    endtask

    task automatic waitCyc(input int n);
        int guard = 0;
        while (cyc < n && guard < 20000) begin
            @(negedge pixclk);
            guard++;
        end
        vectors++;
        if (cyc < n) begin
            miscompares++;
            $display("[TB] FAIL wait_cycle: reached %0d, needed %0d", cyc, n);
        end
    endtask

    // Scoreboard monitor plus frame-level statistics for the shrunken instance.
    initial begin
        forever begin
            @(negedge pixclk);
            if (reset_n === 1'b1) begin
                while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
                    mon_e = exp_q.pop_front();
                    if (mon_e.cyc < cyc) begin
                        vectors++;
                        miscompares++;
                        $display("[TB] FAIL %s: sampled at cycle %0d, required at cycle %0d", mon_e.name, cyc, mon_e.cyc);
                    end else if (mon_e.is_addr) begin
                        checkOutput(mon_e.name, {14'b0, raddr}, {14'b0, mon_e.addr});
                    end else begin
                        checkOutput(mon_e.name, {17'b0, vga_r, vga_g, vga_b, vga_hs, vga_vs, frame_start},
                                    {17'b0, mon_e.rgb, mon_e.hs, mon_e.vs, mon_e.fs});
                    end
                end
                if (seg == 0) begin
                    if (vga_hs && !prev_hs) begin
                        if (hs_first < 0) hs_first = cyc;
                        else              hs_period = cyc - hs_rise;
                        hs_rise = cyc;
                    end
                    if (!vga_hs && prev_hs) hs_width = cyc - hs_rise;
                    if (vga_vs && !prev_vs) begin
                        if (vs_rise >= 0) vs_period = cyc - vs_rise;
                        vs_rise = cyc;
                    end
                    if (!vga_vs && prev_vs) vs_width = cyc - vs_rise;
                    if (cyc >= 4 && (cyc - 4) / FRAME < 3) begin
                        if ({vga_r, vga_g, vga_b} != 12'h000) lit_cnt[(cyc - 4) / FRAME]++;
                        if (frame_start)                      fs_cnt[(cyc - 4) / FRAME]++;
                    end
                end
            end
            prev_hs = vga_hs;
            prev_vs = vga_vs;
        end
    end

    // Full-timing instance: hsync edges, and nothing but blanking during the first lines.
    initial begin
        forever begin
            @(negedge pixclk);
            if (reset_n_full === 1'b1) begin
                if (hs_full && !prev_hs_full) begin
                    if (full_rise1 < 0)      full_rise1 = cyc_full;
                    else if (full_rise2 < 0) full_rise2 = cyc_full;
                end
                if (!hs_full && prev_hs_full && full_fall1 < 0) full_fall1 = cyc_full;
                if (raddr_full != 18'd0 || {r_full, g_full, b_full} != 12'h000 || vs_full || fs_full)
                    full_bad++;
            end
            prev_hs_full = hs_full;
        end
    end

    initial begin
        int guard;
        reset_n      = 1'b0;
        reset_n_full = 1'b0;
        tint         = 2'b00;
        ram_mode     = 1'b0;
        for (int i = 0; i < 3; i++) begin
            lit_cnt[i] = 0;
            fs_cnt[i]  = 0;
        end
        repeat (3) @(negedge pixclk);
        checkOutput("reset_rgb",   {20'b0, vga_r, vga_g, vga_b}, 32'h0);
        checkOutput("reset_hs",    {31'b0, vga_hs}, 32'h0);
        checkOutput("reset_vs",    {31'b0, vga_vs}, 32'h0);
        checkOutput("reset_fs",    {31'b0, frame_start}, 32'h0);
        checkOutput("reset_raddr", {14'b0, raddr}, 32'h0);
        checkOutput("reset_hs_full", {31'b0, hs_full}, 32'h0);

        applyStimulus(0);
        @(negedge pixclk);
        reset_n      = 1'b1;
        reset_n_full = 1'b1;

        waitCyc(160);
        ram_mode = 1'b1;
        waitCyc(300);
        tint = 2'b01;
        waitCyc(759);
        seg = 1;
        #1 reset_n = 1'b0;
        #1;
        checkOutput("async_rst_rgb",   {20'b0, vga_r, vga_g, vga_b}, 32'h0);
        checkOutput("async_rst_hs",    {31'b0, vga_hs}, 32'h0);
        checkOutput("async_rst_vs",    {31'b0, vga_vs}, 32'h0);
        checkOutput("async_rst_fs",    {31'b0, frame_start}, 32'h0);
        checkOutput("async_rst_raddr", {14'b0, raddr}, 32'h0);

        repeat (3) @(negedge pixclk);
        applyStimulus(1);
        reset_n = 1'b1;
        waitCyc(300);

        guard = 0;
        while (cyc_full < 1910 && guard < 5000) begin
            @(negedge pixclk);
            guard++;
        end

        checkOutput("hs_first_edge", hs_first,   32'd14);
        checkOutput("hs_period",     hs_period,  32'd16);
        checkOutput("hs_width",      hs_width,   32'd3);
        checkOutput("vs_period",     vs_period,  32'd224);
        checkOutput("vs_width",      vs_width,   32'd32);
        checkOutput("lit_frame0",    lit_cnt[0], 32'd2);
        checkOutput("lit_frame1",    lit_cnt[1], 32'd48);
        checkOutput("lit_frame2",    lit_cnt[2], 32'd48);
        checkOutput("fs_frame0",     fs_cnt[0],  32'd1);
        checkOutput("fs_frame1",     fs_cnt[1],  32'd1);
        checkOutput("fs_frame2",     fs_cnt[2],  32'd1);
        checkOutput("full_hs_rise1", full_rise1, 32'd844);
        checkOutput("full_hs_fall1", full_fall1, 32'd972);
        checkOutput("full_hs_rise2", full_rise2, 32'd1900);
        checkOutput("full_top_blank", full_bad,  32'd0);

        while (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            vectors++;
            miscompares++;
            $display("[TB] FAIL %s: never reached, required at cycle %0d", mon_e.name, mon_e.cyc);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
